// File: rtl/mem_access.sv
// Data-memory access stage: legality check, byte-lane steering, request/grant/response
// handshake with the data memory, and load-data alignment/extension for writeback.
module mem_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] ld_data_o,
    output logic            exc_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e          state_q, state_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic            done_q, exc_q;

    logic            legal, accept, complete, in_req;
    logic [3:0]      be;
    logic [XLEN-1:0] lanes, ld_ext;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Stores only exist for B/H/W; halves and words must be naturally aligned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        legal = 1'b0;
        case (req_funct3_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~req_addr_i[0];
            3'b010:  legal = (req_addr_i[1:0] == 2'b00);
            3'b100:  legal = ~req_we_i;
            3'b101:  legal = ~req_we_i & ~req_addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    assign accept   = (state_q == IDLE) & req_valid_i & legal;
    assign complete = (state_q == WAIT) & dmem_rvalid_i;
    assign in_req   = (state_q == REQ);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = REQ;
            REQ:     if (dmem_gnt_i)    state_d = WAIT;
            WAIT:    if (dmem_rvalid_i) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        lanes = '0;
        case (funct3_q[1:0])
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00:   lanes = {4{wdata_q[7:0]}};
                2'b01:   lanes = {2{wdata_q[15:0]}};
                default: lanes = wdata_q;
            endcase
        end
    end

    assign byte_sel = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        ld_ext = dmem_rdata_i;
        case (funct3_q)
            3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  ld_ext = {24'b0, byte_sel};
            3'b101:  ld_ext = {16'b0, half_sel};
            default: ld_ext = dmem_rdata_i;
        endcase
        ld_data_d = (complete & ~we_q) ? ld_ext : ld_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
            done_q    <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            ld_data_q <= ld_data_d;
            done_q    <= complete;
            exc_q     <= (state_q == IDLE) & req_valid_i & ~legal;
            if (accept) begin
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
            end
        end
    end

    // Bus fields are gated by REQ so a reset drops the request combinationally.
    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req & we_q;
    assign dmem_be_o    = in_req ? be : 4'b0000;
    assign dmem_addr_o  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata_o = in_req ? lanes : '0;

    assign stall_o   = (state_q != IDLE) | accept;
    assign done_o    = done_q;
    assign exc_o     = exc_q;
    assign ld_data_o = ld_data_q;

endmodule

// File: doc/mem_access.md
# mem_access

Data-memory access stage of the ares-riscv core, between execute and writeback. It takes a load/store request (ALU-computed address, store data, funct3), checks alignment, generates byte enables, and runs a request/grant/response handshake with the data memory. It then aligns and sign/zero-extends load data into the 32-bit word that writeback selects as its memory source. It stalls the pipeline while a bus transaction is outstanding.

## Interface
Parameters:
- XLEN, 32, data/address width (only 32 supported)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  execute stage presents a memory op this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
- req_addr_i  in  32  byte address from ALU
- req_wdata_i  in  32  store data (rs2), LSB-justified
- stall_o  out  1  hold upstream pipeline
- done_o  out  1  one-cycle pulse: access completed
- ld_data_o  out  32  aligned, extended load result (feeds writeback memory input)
- exc_o  out  1  one-cycle pulse: misaligned or illegal funct3; no bus access
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  bus write
- dmem_be_o  out  4  byte enables
- dmem_addr_o  out  32  word address (addr[1:0] forced 00)
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response (read data, or store ack)
- dmem_rdata_i  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: if req_valid_i and op legal, latch we/funct3/addr/wdata and go to REQ. If req_valid_i and illegal, pulse exc_o next cycle and stay IDLE.
- Illegal means: H/HU with addr[0]=1; W with addr[1:0]≠00; funct3 011/110/111; store with funct3 100/101.
- REQ: dmem_req_o=1 with latched fields held stable. On dmem_gnt_i go to WAIT.
- WAIT: dmem_req_o=0. On dmem_rvalid_i go to IDLE and pulse done_o the following cycle. For loads, register the extracted data into ld_data_o in the same cycle.
- Byte enables by size and offset:
  - B: 0001 shifted left by addr[1:0].
  - H: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - W: 1111.
  - Loads drive the same enables.
- Store data lanes: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata. Loads drive dmem_wdata_o=0.
- Load extraction: select byte/half by addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- ld_data_o updates only on load completion and holds otherwise; stores leave it unchanged.
- stall_o = (state≠IDLE) | (state==IDLE & req_valid_i & legal). Combinational.
- Upstream holds inputs while stall_o=1. Inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE; stall_o 0, done_o 0, exc_o 0, ld_data_o 0, dmem_req_o 0, dmem_we_o 0, dmem_be_o 0, dmem_addr_o 0, dmem_wdata_o 0.
- Reset mid-transaction aborts immediately: dmem_req_o drops asynchronously, no done_o, and any late rvalid after reset is ignored.
- Minimum latency (gnt in first REQ cycle, rvalid one cycle after gnt):
  - accept at cycle 0
  - dmem_req_o at cycle 1
  - WAIT at cycle 2 with rvalid
  - done_o and ld_data_o valid at cycle 3
  - stall_o high cycles 0–2
- Grant delays extend REQ one cycle each; request fields stay constant.
- dmem_rvalid_i never arrives in the same cycle as dmem_gnt_i. rvalid in IDLE or REQ is ignored.
- In the done_o cycle the FSM is IDLE: a new req_valid_i is accepted back-to-back and stall_o may rise again that cycle.
- exc_o pulses one cycle after the illegal request, with stall_o low and dmem_req_o never asserted.

## Test plan
- LW addr 0x100, gnt immediately, rvalid next cycle, rdata 0xDEADBEEF -> dmem_be_o 1111, dmem_addr_o 0x100, done_o at cycle 3, ld_data_o 0xDEADBEEF, stall_o high exactly 3 cycles.
- LB addr 0x103, rdata 0x80112233 -> be 1000, ld_data_o 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102 -> 0xFFFF8011. LHU -> 0x00008011.
- SB addr 0x201, wdata 0x000000A5 -> be 0010, dmem_wdata_o 0xA5A5A5A5, dmem_we_o 1, ld_data_o unchanged. SH addr 0x202, wdata 0x1234 -> be 1100, wdata 0x12341234.
- LW addr 0x102, and SH addr 0x301 -> exc_o pulses once each, dmem_req_o stays 0, stall_o never asserts, no done_o.
- gnt delayed 4 cycles, rvalid 2 cycles after gnt -> dmem_req_o held 5 cycles with constant addr/be, stall_o held throughout, single done_o. Second back-to-back LW accepted in the done_o cycle.
- rst_n pulled low in WAIT -> all outputs 0 at once, FSM IDLE. rvalid after reset release produces no done_o.
